imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that fills the instruction buffer read by the instruction fetch unit. It accepts a framed word stream over a valid/ready handshake, checks the frame, and writes each payload word into the instruction buffer at consecutive addresses. On successful completion it publishes the frame's base address as the fetch start PC. It is the write side of the instruction buffer; the fetch unit is the read side.

## Interface
- ADDR_W, 10, instruction buffer address width (buffer depth 2^ADDR_W)
- DATA_W, 16, instruction/stream word width
- SYNC_WORD, 16'hA55A, frame header value
- Clk  input  1  clock; all logic on posedge
- Reset  input  1  synchronous, active-high reset
- in_valid  input  1  stream word present
- in_data  input  DATA_W  stream word
- in_ready  output  1  loader can accept a word; beat = in_valid & in_ready at posedge
- wr_en  output  1  instruction buffer write strobe
- wr_addr  output  ADDR_W  write address
- wr_data  output  DATA_W  write data
- busy  output  1  frame in progress (states BASE, LEN, DATA, CSUM)
- done  output  1  one-cycle pulse: frame loaded and accepted
- err  output  1  sticky frame error
- start_pc  output  16  base address of last good frame
- start_pc_valid  output  1  start_pc holds a good frame's base; sticky

## Operation
- Frame: SYNC_WORD, base (16b), length N (16b), N payload words, checksum word.
- States: IDLE, BASE, LEN, DATA, CSUM, DONE.
- IDLE: beat == SYNC_WORD -> BASE, clears err; any other beat discarded, state unchanged.
- BASE: beat latched as base; wr pointer = base[ADDR_W-1:0] -> LEN.
- LEN: N == 0 or N > 2^ADDR_W -> err=1, IDLE. Else latch count=N, clear checksum -> DATA.
- DATA: each beat writes in_data at pointer; pointer += 1 modulo 2^ADDR_W (wraps 2^ADDR_W-1 -> 0); checksum += in_data modulo 2^16; count -= 1; after Nth beat -> CSUM.
- CSUM: beat == checksum -> DONE; mismatch -> err=1, IDLE, no done. Already-written words stay written (no rollback).
- DONE: one cycle; done=1, start_pc=base, start_pc_valid=1; in_ready=0 -> IDLE.
- A SYNC_WORD value inside BASE/LEN/DATA/CSUM is ordinary data, not resync.
- start_pc/start_pc_valid change only in DONE; a failed frame leaves previous values.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, start_pc=0, start_pc_valid=0, state IDLE.
- in_ready registered: 1 from the first cycle after Reset deasserts; 0 only in DONE and during Reset.
- Beats presented while Reset is high are not accepted.
- Write latency: payload beat at edge t -> wr_en=1 with wr_addr/wr_data for the cycle after t; wr_en one cycle per beat; back-to-back beats give back-to-back writes.
- Checksum beat at edge t -> done=1 in the cycle after t; in_ready=0 that cycle; in_ready=1 the following cycle.
- in_valid low stalls any state indefinitely with no output change except wr_en/done returning to 0.
- Reset mid-frame: next cycle all outputs at reset values, including start_pc_valid; the pending write of the final pre-reset beat is dropped if Reset is high at that edge.
- Throughput: 1 word/cycle; frame of N words occupies N+4 beats plus 1 DONE cycle.

## Configuration
- IMEM_LOADER_CSUM_EN defined: CSUM state present, checksum word required as described.
- Undefined: no CSUM state and no checksum accumulator; after the Nth payload beat -> DONE directly (done in the cycle after the last write beat, same cycle as its wr_en). err only from illegal length. The word following the payload is treated in IDLE (discarded unless SYNC_WORD).

## Test plan
- Good frame A55A, 0010, 0003, 0001, 0002, 0003, 0006 back-to-back -> writes (0x010,1),(0x011,2),(0x012,3) on consecutive cycles; done pulse 1 cycle after checksum; start_pc=0x0010, start_pc_valid=1, err=0.
- Wrap: base 0x03FF, N=2, words 1111, 2222, checksum 3333 -> writes at 0x3FF then 0x000; done=1.
- Bad checksum 0x0000 on the first frame -> three writes occur, err=1, done never asserted, start_pc_valid unchanged; next SYNC_WORD beat clears err.
- Length 0 and length 0x0401 -> err=1 after LEN beat, no wr_en, state returns to IDLE; leading garbage 1234, 5678 before SYNC is ignored.
- Random in_valid gaps on a 16-word frame -> writes track beats exactly, done once; Reset asserted mid-DATA -> all outputs reset next cycle, subsequent good frame loads correctly.
- With IMEM_LOADER_CSUM_EN undefined: frame A55A, 0000, 0001, BEEF -> one write (0x000, BEEF), done in the same cycle as wr_en.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction buffer write-side loader: framed valid/ready word stream in, buffer writes out.
// Optional feature macro: IMEM_LOADER_CSUM_EN adds the trailing checksum word and its CSUM state.
module imem_loader #(
  parameter int unsigned            ADDR_W    = 10,
  parameter int unsigned            DATA_W    = 16,
  parameter logic [DATA_W-1:0]      SYNC_WORD = 16'hA55A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       start_pc,
  output logic              start_pc_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BASE,
    S_LEN,
    S_DATA,
`ifdef IMEM_LOADER_CSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  // Largest legal frame length: the whole buffer.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t            state, state_next;
  logic [15:0]       base_q;
  logic [ADDR_W-1:0] ptr;
  logic [15:0]       count;
  logic [15:0]       len_w;
  logic              beat;
  logic              len_bad;
`ifdef IMEM_LOADER_CSUM_EN
  logic [15:0]       csum;
  logic              csum_bad;
`endif

  assign busy = (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_next = state;
    beat       = in_valid & in_ready;
    len_w      = 16'(in_data);
    len_bad    = (len_w == 16'd0) || ({1'b0, len_w} > DEPTH);
`ifdef IMEM_LOADER_CSUM_EN
    csum_bad   = (16'(in_data) != csum);
`endif
    case (state)
      S_IDLE: if (beat && in_data == SYNC_WORD) state_next = S_BASE;
      S_BASE: if (beat) state_next = S_LEN;
      S_LEN:  if (beat) state_next = len_bad ? S_IDLE : S_DATA;
      S_DATA: begin
        if (beat && count == 16'd1) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_next = S_CSUM;
`else
          state_next = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM: if (beat) state_next = csum_bad ? S_IDLE : S_DONE;
`endif
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready       <= 1'b0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      start_pc       <= '0;
      start_pc_valid <= 1'b0;
      base_q         <= '0;
      ptr            <= '0;
      count          <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum           <= '0;
`endif
    end else begin
      wr_en    <= 1'b0;
      done     <= 1'b0;
      // Ready is dropped for exactly the DONE cycle.
      in_ready <= (state_next != S_DONE);
      case (state)
        S_IDLE: if (beat && in_data == SYNC_WORD) err <= 1'b0;
        S_BASE: begin
          if (beat) begin
            base_q <= 16'(in_data);
            ptr    <= ADDR_W'(in_data);
          end
        end
        S_LEN: begin
          if (beat) begin
            if (len_bad) begin
              err <= 1'b1;
            end else begin
              count <= len_w;
`ifdef IMEM_LOADER_CSUM_EN
              csum  <= '0;
`endif
            end
          end
        end
        S_DATA: begin
          if (beat) begin
            wr_en   <= 1'b1;
            wr_addr <= ptr;
            wr_data <= in_data;
            ptr     <= ptr + ADDR_W'(1);
            count   <= count - 16'd1;
`ifdef IMEM_LOADER_CSUM_EN
            csum    <= csum + 16'(in_data);
`endif
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM: if (beat && csum_bad) err <= 1'b1;
`endif
        default: ;
      endcase
      if (state_next == S_DONE) begin
        done           <= 1'b1;
        start_pc       <= base_q;
        start_pc_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are driven, expected writes go to a scoreboard
// queue and are popped by a monitor on the falling edge.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam logic [15:0] SYNC = 16'hA55A;
`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef struct packed {
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, wr_en, busy, done, err, start_pc_valid;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data, start_pc;

  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  int          exp_done = 0;
  logic [15:0] exp_pc = '0;
  logic        exp_pc_valid = 1'b0;
  wr_t         sb[$];
  logic [15:0] payload[$];
  bit          prev_done = 1'b0;
  wr_t         got;

  imem_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .start_pc(start_pc),
    .start_pc_valid(start_pc_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: every write must match the oldest expected write; done pulse timing is checked here.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", wr_addr, wr_data);
      end else begin
        got = sb.pop_front();
        if (wr_addr !== got.addr || wr_data !== got.data) begin
          errors++;
          $display("FAIL write_match: got addr=%h data=%h, expected addr=%h data=%h",
                   wr_addr, wr_data, got.addr, got.data);
        end
      end
    end
    if (done === 1'b1) begin
      done_seen++;
      checks++;
      if (in_ready !== 1'b0 || wr_en !== !CSUM_EN) begin
        errors++;
        $display("FAIL done_cycle: got in_ready=%b wr_en=%b, expected in_ready=0 wr_en=%b",
                 in_ready, wr_en, !CSUM_EN);
      end
    end
    if (prev_done) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_done: got in_ready=%b, expected 1", in_ready);
      end
    end
    prev_done = (done === 1'b1);
  end

  task automatic send(input logic [15:0] d, input int gap);
    bit acc = 1'b0;
    int tries = 0;
    for (int k = 0; k < gap; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    while (!acc && tries < 50) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      acc      = (in_ready === 1'b1);
      @(posedge clk);
      tries++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %h never accepted, expected acceptance within 50 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Drives SYNC, base, length, the payload queue and a trailing word (checksum, or corrupted).
  task automatic send_frame(input logic [15:0] base, input int max_gap, input bit good_csum);
    logic [15:0] sum = '0;
    logic [15:0] tr;
    wr_t e;
    send(SYNC, $urandom_range(0, max_gap));
    send(base, $urandom_range(0, max_gap));
    send(16'(payload.size()), $urandom_range(0, max_gap));
    for (int i = 0; i < payload.size(); i++) begin
      e.addr = base[9:0] + 10'(i);
      e.data = payload[i];
      sb.push_back(e);
      sum = sum + payload[i];
      send(payload[i], $urandom_range(0, max_gap));
    end
    tr = good_csum ? sum : ~sum;
    if (CSUM_EN || tr != SYNC) send(tr, $urandom_range(0, max_gap));
    if (!CSUM_EN || good_csum) begin
      exp_done++;
      exp_pc = base;
      exp_pc_valid = 1'b1;
    end
  endtask

  task automatic end_frame(input string name);
    idle(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_writes_missing: %0d writes still expected, expected 0", name, sb.size());
      sb.delete();
    end
    checks++;
    if (done_seen != exp_done) begin
      errors++;
      $display("FAIL %s_done_count: got %0d, expected %0d", name, done_seen, exp_done);
    end
    checks++;
    if (start_pc !== exp_pc || start_pc_valid !== exp_pc_valid || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_status: got start_pc=%h valid=%b busy=%b, expected %h %b 0",
               name, start_pc, start_pc_valid, busy, exp_pc, exp_pc_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = SYNC;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, busy, done, err, start_pc, start_pc_valid} !== '0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b we=%b a=%h d=%h busy=%b done=%b err=%b pc=%h pcv=%b, expected all 0",
               in_ready, wr_en, wr_addr, wr_data, busy, done, err, start_pc, start_pc_valid);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b busy=%b, expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    payload.delete();
    payload.push_back(16'h0001);
    payload.push_back(16'h0002);
    payload.push_back(16'h0003);
    send_frame(16'h0010, 0, 1'b1);
    end_frame("basic");
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL basic_err: got %b, expected 0", err);
    end
  endtask

  task automatic test_wrap();
    payload.delete();
    payload.push_back(16'h1111);
    payload.push_back(16'h2222);
    send_frame(16'h03FF, 0, 1'b1);
    end_frame("wrap");
  endtask

  task automatic test_bad_len();
    send(16'h1234, 0);
    send(16'h5678, 0);
    idle(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL garbage_ignored: got busy=%b, expected 0", busy);
    end
    send(SYNC, 0);
    send(16'h0020, 0);
    send(16'h0000, 0);
    idle(1);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len_zero: got err=%b busy=%b, expected 1 0", err, busy);
    end
    send(SYNC, 0);
    idle(1);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_clear_on_sync: got err=%b busy=%b, expected 0 1", err, busy);
    end
    send(16'h0020, 0);
    send(16'h0401, 0);
    idle(1);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len_too_big: got err=%b busy=%b, expected 1 0", err, busy);
    end
    end_frame("bad_len");
  endtask

  task automatic test_max_len();
    payload.delete();
    for (int i = 0; i < 1024; i++) payload.push_back(16'(i));
    send_frame(16'h0100, 0, 1'b1);
    end_frame("max_len");
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL max_len_err: got %b, expected 0", err);
    end
  endtask

  task automatic test_gaps();
    payload.delete();
    for (int i = 0; i < 16; i++) payload.push_back(i == 5 ? SYNC : 16'h1000 + 16'(i));
    send_frame(16'h0234, 3, 1'b1);
    end_frame("gaps");
  endtask

`ifdef IMEM_LOADER_CSUM_EN
  task automatic test_bad_csum();
    payload.delete();
    payload.push_back(16'h0001);
    payload.push_back(16'h0002);
    payload.push_back(16'h0003);
    send_frame(16'h0010, 0, 1'b0);
    idle(1);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL bad_csum_err: got %b, expected 1", err);
    end
    end_frame("bad_csum");
    send(SYNC, 0);
    idle(1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL bad_csum_clear: got err=%b, expected 0", err);
    end
    send(16'h0000, 0);
    send(16'h0000, 0);
    idle(1);
  endtask
`else
  task automatic test_no_csum();
    payload.delete();
    payload.push_back(16'hBEEF);
    send_frame(16'h0000, 0, 1'b1);
    end_frame("no_csum");
  endtask
`endif

  task automatic test_reset_mid();
    wr_t e;
    send(SYNC, 0);
    send(16'h0200, 0);
    send(16'h0008, 0);
    for (int i = 0; i < 2; i++) begin
      e.addr = 10'h200 + 10'(i);
      e.data = 16'hD000 + 16'(i);
      sb.push_back(e);
      send(e.data, 0);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 16'hD002;
    reset = 1'b1;
    @(negedge clk);
    exp_pc = '0;
    exp_pc_valid = 1'b0;
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, busy, done, err, start_pc, start_pc_valid} !== '0) begin
      errors++;
      $display("FAIL mid_reset_values: got rdy=%b we=%b a=%h d=%h busy=%b done=%b err=%b pc=%h pcv=%b, expected all 0",
               in_ready, wr_en, wr_addr, wr_data, busy, done, err, start_pc, start_pc_valid);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    idle(1);
    payload.delete();
    payload.push_back(16'hC0DE);
    payload.push_back(16'hF00D);
    payload.push_back(16'h0001);
    send_frame(16'h0123, 1, 1'b1);
    end_frame("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_bad_len();
    test_max_len();
    test_gaps();
`ifdef IMEM_LOADER_CSUM_EN
    test_bad_csum();
`else
    test_no_csum();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
